scu_wb_resp_unit: RTL and testbench
===================================

# scu_wb_resp_unit

SCU-side responder for private-cache evict/writeback traffic. It accepts Evict, WriteBackFull and WriteBackPartial requests from an L1D bank and returns a WriteBack_Ack carrying an allocated scu_tid. For writebacks it then collects the matching data beat and issues one strobed line write to the memory/LLC write port. It also exposes an address-hazard lookup so SCU read flows can stall on lines whose writeback is in flight.

## Interface
- N_WB_TID, 4, number of tracking entries; scu_tid = entry index; must satisfy 2 ≤ N_WB_TID ≤ 2^SCU_TID_W.
- ADDR_W, 56, physical line address width, cache_scu_cc_req_t.addr with offset bits dropped.
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- pc_scu_evict_vld_i  in  1  request valid.
- pc_scu_evict_i  in  cache_scu_cc_req_t  request (id, rtype, addr).
- pc_scu_evict_rdy_o  out  1  request ready.
- scu_pc_resp_vld_o  out  1  ack valid.
- scu_pc_resp_o  out  cache_scu_cc_resp_t  ack payload.
- scu_pc_resp_rdy_i  in  1  ack ready.
- pc_scu_data_vld_i  in  1  data valid.
- pc_scu_data_i  in  cache_scu_cc_data_t  data (id.scu_tid, data[DATA_BURST_NUM], data_valid).
- pc_scu_data_rdy_o  out  1  data ready.
- mem_wr_vld_o  out  1  memory write valid.
- mem_wr_addr_o  out  ADDR_W  memory write line address.
- mem_wr_data_o  out  DATA_BURST_NUM*DATA_LENGTH_PER_PKG  line data.
- mem_wr_strb_o  out  DATA_BURST_NUM  per-segment write enable.
- mem_wr_rdy_i  in  1  memory write ready.
- lookup_addr_i  in  ADDR_W  hazard query address.
- lookup_hit_o  out  1  query matches a valid entry.
- wb_err_o  out  1  sticky protocol-error flag.

## Operation
- Each entry holds valid, addr, req id (cid, bid, pc_tid), is_wb, and a state.
- Entry states: FREE, ACK (ack pending), DATA (waiting for data), MEM (write buffered).
- Allocation:
  - pc_scu_evict_rdy_o = OR of FREE entries, computed from registered state.
  - On handshake, the lowest-index FREE entry moves to ACK.
  - is_wb = (rtype ∈ {WriteBackFull, WriteBackPartial}).
  - Any other rtype is dropped, is still handshaken, and sets wb_err_o.
- Ack:
  - scu_pc_resp_vld_o = any entry in ACK; the lowest index in ACK wins.
  - Payload: rtype = WriteBack_Ack, id.cid/bid/pc_tid copied from the entry, id.scu_tid = index, all other fields zero.
  - On handshake: is_wb ? ACK→DATA : ACK→FREE.
- Data:
  - pc_scu_data_rdy_o = ~mem_buf_vld. A single write buffer is shared by all entries.
  - On handshake with entry[scu_tid] in DATA: capture addr/data into the buffer and move entry→MEM.
  - strb = data_valid for WriteBackPartialData, all ones for WriteBackFullData.
  - If entry[scu_tid] is not in DATA: the beat is consumed and dropped, and wb_err_o is set.
- Memory:
  - mem_wr_*_o are driven from the buffer.
  - On mem_wr_vld_o & mem_wr_rdy_i: clear the buffer and move the owning entry MEM→FREE.
- Hazard: lookup_hit_o = OR over entries in ACK/DATA/MEM where addr == lookup_addr_i. Purely combinational.
- wb_err_o is cleared only by reset.

## Timing
- Reset (async assert, sync release):
  - All entries FREE, buffer empty, wb_err_o = 0.
  - Hence pc_scu_evict_rdy_o = 1, scu_pc_resp_vld_o = 0, pc_scu_data_rdy_o = 1, mem_wr_vld_o = 0, lookup_hit_o = 0.
  - Outputs drive these values immediately while rst is low.
- Request accepted at cycle N → scu_pc_resp_vld_o no earlier than N+1.
- Data accepted at M → mem_wr_vld_o = 1 at M+1, held stable until rdy.
- Memory handshake at K → entry FREE and reallocatable from K+1. The freed index is not reallocated in cycle K.
- A held valid with rdy low: the payload must stay stable. The block itself never drops a presented ack or write.
- Full: with all N_WB_TID entries non-FREE, pc_scu_evict_rdy_o = 0. It rises the cycle after any entry frees.
- Simultaneous events within one cycle all take effect independently:
  - allocation
  - ack handshake
  - data capture
  - memory handshake
- Buffer full plus arriving data: pc_scu_data_rdy_o = 0. Ready returns the cycle after the memory handshake; there is no same-cycle bypass.
- Reset mid-operation discards all entries and buffered data without issuing writes.

## Test plan
- Evict:
  - Stimulus: Evict, addr 0x1000, cid 1, bid 0.
  - Response: one ack with scu_tid 0 and cid 1; no memory write; entry FREE after the ack handshake.
- Full writeback:
  - Stimulus: WriteBackFull at 0x2000; after the ack, data with scu_tid 0 and pattern 0xA5.
  - Response: mem_wr_vld_o one cycle after data, addr 0x2000, strb all ones; lookup_hit_o for 0x2000 high until the memory handshake completes.
- Partial writeback:
  - Stimulus: WriteBackPartialData with data_valid 0b01 (two segments).
  - Response: mem_wr_strb_o = 0b01.
- Fill to full:
  - Stimulus: 4 writebacks with no data sent.
  - Response: scu_tid 0..3 in order; pc_scu_evict_rdy_o = 0 while all four are outstanding.
  - Follow-up: complete scu_tid 2. Rdy rises the cycle after its memory handshake, and the next request gets scu_tid 2.
- Backpressure:
  - Stimulus: hold mem_wr_rdy_i = 0 for 5 cycles with a second data beat pending.
  - Response: pc_scu_data_rdy_o = 0 and mem_wr_* stable throughout; the second write issues after the first handshake.
- Errors:
  - Stimulus: data with scu_tid 3 while entry 3 is FREE, or a request with an illegal rtype.
  - Response: beat consumed, wb_err_o = 1 and sticky, entries unaffected.
- Reset mid-operation:
  - Stimulus: assert rst low while the buffer is full.
  - Response: mem_wr_vld_o = 0 immediately; all entries FREE.

Source files
------------

// File: rtl/scu_wb_resp_unit.sv
// SCU responder for L1D evict/writeback requests: ack allocation, data capture, line write.
// Packets: req {id,rtype,addr}, resp {id,rtype}, data {rtype,id,line,data_valid}; id {cid,bid,pc_tid,scu_tid}.
module scu_wb_resp_unit #(
    parameter int N_WB_TID            = 4,
    parameter int ADDR_W              = 56,
    parameter int SCU_TID_W           = 2,
    parameter int CID_W               = 2,
    parameter int BID_W               = 2,
    parameter int PC_TID_W            = 4,
    parameter int RTYPE_W             = 4,
    parameter int DATA_BURST_NUM      = 2,
    parameter int DATA_LENGTH_PER_PKG = 64,
    localparam int ID_W   = CID_W + BID_W + PC_TID_W + SCU_TID_W,
    localparam int LINE_W = DATA_BURST_NUM * DATA_LENGTH_PER_PKG,
    localparam int REQ_W  = ID_W + RTYPE_W + ADDR_W,
    localparam int RESP_W = ID_W + RTYPE_W,
    localparam int DPKT_W = RTYPE_W + ID_W + LINE_W + DATA_BURST_NUM
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pc_scu_evict_vld_i,
    input  logic [REQ_W-1:0]          pc_scu_evict_i,
    output logic                      pc_scu_evict_rdy_o,
    output logic                      scu_pc_resp_vld_o,
    output logic [RESP_W-1:0]         scu_pc_resp_o,
    input  logic                      scu_pc_resp_rdy_i,
    input  logic                      pc_scu_data_vld_i,
    input  logic [DPKT_W-1:0]         pc_scu_data_i,
    output logic                      pc_scu_data_rdy_o,
    output logic                      mem_wr_vld_o,
    output logic [ADDR_W-1:0]         mem_wr_addr_o,
    output logic [LINE_W-1:0]         mem_wr_data_o,
    output logic [DATA_BURST_NUM-1:0] mem_wr_strb_o,
    input  logic                      mem_wr_rdy_i,
    input  logic [ADDR_W-1:0]         lookup_addr_i,
    output logic                      lookup_hit_o,
    output logic                      wb_err_o
);

    localparam logic [RTYPE_W-1:0] RT_EVICT = RTYPE_W'(0);
    localparam logic [RTYPE_W-1:0] RT_WBF   = RTYPE_W'(1);
    localparam logic [RTYPE_W-1:0] RT_WBP   = RTYPE_W'(2);
    localparam logic [RTYPE_W-1:0] RT_ACK   = RTYPE_W'(3);
    localparam logic [RTYPE_W-1:0] RT_WBPD  = RTYPE_W'(5);

    typedef enum logic [1:0] {
        S_FREE,
        S_ACK,
        S_DATA,
        S_MEM
    } state_e;

    logic [ADDR_W-1:0]         req_addr;
    logic [RTYPE_W-1:0]        req_rtype;
    logic [CID_W-1:0]          req_cid;
    logic [BID_W-1:0]          req_bid;
    logic [PC_TID_W-1:0]       req_pctid;
    logic [SCU_TID_W-1:0]      req_stid;
    logic [RTYPE_W-1:0]        dat_rtype;
    logic [CID_W-1:0]          dat_cid;
    logic [BID_W-1:0]          dat_bid;
    logic [PC_TID_W-1:0]       dat_pctid;
    logic [SCU_TID_W-1:0]      dat_tid;
    logic [LINE_W-1:0]         dat_line;
    logic [DATA_BURST_NUM-1:0] dat_dv;
    logic [DATA_BURST_NUM-1:0] dat_strb;

    assign {req_cid, req_bid, req_pctid, req_stid, req_rtype, req_addr} = pc_scu_evict_i;
    assign {dat_rtype, dat_cid, dat_bid, dat_pctid, dat_tid, dat_line, dat_dv} = pc_scu_data_i;

    logic unused_fields;
    assign unused_fields = ^{req_stid, dat_cid, dat_bid, dat_pctid};

    state_e              state_q [N_WB_TID];
    state_e              state_d [N_WB_TID];
    logic [ADDR_W-1:0]   addr_q  [N_WB_TID];
    logic [CID_W-1:0]    cid_q   [N_WB_TID];
    logic [BID_W-1:0]    bid_q   [N_WB_TID];
    logic [PC_TID_W-1:0] pctid_q [N_WB_TID];
    logic [N_WB_TID-1:0] is_wb_q;

    logic                      buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0]         buf_addr_q;
    logic [LINE_W-1:0]         buf_data_q;
    logic [DATA_BURST_NUM-1:0] buf_strb_q;
    logic [SCU_TID_W-1:0]      buf_tid_q;
    logic                      err_q, err_d;

    logic                 any_free, any_ack, hit;
    logic [SCU_TID_W-1:0] free_idx, ack_idx;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        any_ack  = 1'b0;
        ack_idx  = '0;
        hit      = 1'b0;
        for (int i = N_WB_TID - 1; i >= 0; i--) begin
            if (state_q[i] == S_FREE) begin
                any_free = 1'b1;
                free_idx = SCU_TID_W'(i);
            end
            if (state_q[i] == S_ACK) begin
                any_ack = 1'b1;
                ack_idx = SCU_TID_W'(i);
            end
            if (state_q[i] != S_FREE && addr_q[i] == lookup_addr_i) begin
                hit = 1'b1;
            end
        end
    end

    logic alloc_fire, req_legal, req_wb, ack_fire;
    logic data_fire, dat_tid_ok, data_hit, mem_fire;

    assign req_wb     = (req_rtype == RT_WBF) || (req_rtype == RT_WBP);
    assign req_legal  = req_wb || (req_rtype == RT_EVICT);
    assign alloc_fire = pc_scu_evict_vld_i & pc_scu_evict_rdy_o;
    assign ack_fire   = scu_pc_resp_vld_o & scu_pc_resp_rdy_i;
    assign data_fire  = pc_scu_data_vld_i & pc_scu_data_rdy_o;
    assign dat_tid_ok = int'(dat_tid) < N_WB_TID;
    assign data_hit   = dat_tid_ok && (state_q[dat_tid] == S_DATA);
    assign mem_fire   = mem_wr_vld_o & mem_wr_rdy_i;
    assign dat_strb   = (dat_rtype == RT_WBPD) ? dat_dv : '1;

    // Each event acts on an entry in a distinct state, so they never collide.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (alloc_fire) begin
            if (req_legal) begin
                state_d[free_idx] = S_ACK;
            end else begin
                err_d = 1'b1;
            end
        end
        if (ack_fire) begin
            state_d[ack_idx] = is_wb_q[ack_idx] ? S_DATA : S_FREE;
        end
        if (data_fire) begin
            if (data_hit) begin
                state_d[dat_tid] = S_MEM;
            end else begin
                err_d = 1'b1;
            end
        end
        if (mem_fire) begin
            state_d[buf_tid_q] = S_FREE;
        end
    end

    assign buf_vld_d = (buf_vld_q & ~mem_fire) | (data_fire & data_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_WB_TID; i++) begin
                state_q[i] <= S_FREE;
                addr_q[i]  <= '0;
                cid_q[i]   <= '0;
                bid_q[i]   <= '0;
                pctid_q[i] <= '0;
            end
            is_wb_q    <= '0;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_strb_q <= '0;
            buf_tid_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_vld_q <= buf_vld_d;
            err_q     <= err_d;
            if (alloc_fire && req_legal) begin
                addr_q[free_idx]  <= req_addr;
                cid_q[free_idx]   <= req_cid;
                bid_q[free_idx]   <= req_bid;
                pctid_q[free_idx] <= req_pctid;
                is_wb_q[free_idx] <= req_wb;
            end
            if (data_fire && data_hit) begin
                buf_addr_q <= addr_q[dat_tid];
                buf_data_q <= dat_line;
                buf_strb_q <= dat_strb;
                buf_tid_q  <= dat_tid;
            end
        end
    end

    assign pc_scu_evict_rdy_o = any_free;
    assign scu_pc_resp_vld_o  = any_ack;
    assign scu_pc_resp_o      = {cid_q[ack_idx], bid_q[ack_idx], pctid_q[ack_idx], ack_idx, RT_ACK};
    assign pc_scu_data_rdy_o  = ~buf_vld_q;
    assign mem_wr_vld_o       = buf_vld_q;
    assign mem_wr_addr_o      = buf_addr_q;
    assign mem_wr_data_o      = buf_data_q;
    assign mem_wr_strb_o      = buf_strb_q;
    assign lookup_hit_o       = hit;
    assign wb_err_o           = err_q;

endmodule

// File: tb/tb_scu_wb_resp_unit.sv
// Directed bench for scu_wb_resp_unit: evict, writebacks, full table, backpressure, errors, reset.
module tb_scu_wb_resp_unit;

    localparam int ADDR_W = 56;
    localparam int NB     = 2;
    localparam int LINE_W = NB * 64;
    localparam int REQ_W  = 10 + 4 + ADDR_W;
    localparam int RESP_W = 14;
    localparam int DPKT_W = 4 + 10 + LINE_W + NB;

    localparam logic [3:0] RT_EVICT = 4'd0;
    localparam logic [3:0] RT_WBF   = 4'd1;
    localparam logic [3:0] RT_WBP   = 4'd2;
    localparam logic [3:0] RT_ACK   = 4'd3;
    localparam logic [3:0] RT_WBFD  = 4'd4;
    localparam logic [3:0] RT_WBPD  = 4'd5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              evict_vld = 1'b0;
    logic [REQ_W-1:0]  evict = '0;
    logic              evict_rdy;
    logic              resp_vld;
    logic [RESP_W-1:0] resp;
    logic              resp_rdy = 1'b0;
    logic              data_vld = 1'b0;
    logic [DPKT_W-1:0] data = '0;
    logic              data_rdy;
    logic              mem_vld;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_data;
    logic [NB-1:0]     mem_strb;
    logic              mem_rdy = 1'b0;
    logic [ADDR_W-1:0] lk_addr = '0;
    logic              lk_hit;
    logic              err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scu_wb_resp_unit dut (
        .clk                (clk),
        .rst                (rst),
        .pc_scu_evict_vld_i (evict_vld),
        .pc_scu_evict_i     (evict),
        .pc_scu_evict_rdy_o (evict_rdy),
        .scu_pc_resp_vld_o  (resp_vld),
        .scu_pc_resp_o      (resp),
        .scu_pc_resp_rdy_i  (resp_rdy),
        .pc_scu_data_vld_i  (data_vld),
        .pc_scu_data_i      (data),
        .pc_scu_data_rdy_o  (data_rdy),
        .mem_wr_vld_o       (mem_vld),
        .mem_wr_addr_o      (mem_addr),
        .mem_wr_data_o      (mem_data),
        .mem_wr_strb_o      (mem_strb),
        .mem_wr_rdy_i       (mem_rdy),
        .lookup_addr_i      (lk_addr),
        .lookup_hit_o       (lk_hit),
        .wb_err_o           (err)
    );

    function automatic logic [REQ_W-1:0] mk_req(logic [3:0] rt, logic [ADDR_W-1:0] a,
                                                logic [1:0] cid, logic [1:0] bid, logic [3:0] pct);
        return {cid, bid, pct, 2'b00, rt, a};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(logic [1:0] cid, logic [1:0] bid,
                                                  logic [3:0] pct, logic [1:0] tid);
        return {cid, bid, pct, tid, RT_ACK};
    endfunction

    function automatic logic [DPKT_W-1:0] mk_data(logic [3:0] rt, logic [1:0] tid,
                                                  logic [LINE_W-1:0] d, logic [NB-1:0] dv);
        return {rt, 8'h00, tid, d, dv};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        evict_vld = 1'b0;
        resp_rdy = 1'b0;
        data_vld = 1'b0;
        mem_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_req(logic [3:0] rt, logic [ADDR_W-1:0] a,
                          logic [1:0] cid, logic [1:0] bid, logic [3:0] pct);
        int n = 0;
        evict_vld = 1'b1;
        evict = mk_req(rt, a, cid, bid, pct);
        #1;
        while (!evict_rdy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!evict_rdy) begin
            failures++;
            $display("FAIL req_timeout got=%0b exp=1", evict_rdy);
        end
        @(negedge clk);
        evict_vld = 1'b0;
    endtask

    task automatic get_ack(output logic [RESP_W-1:0] r);
        int n = 0;
        resp_rdy = 1'b1;
        #1;
        while (!resp_vld && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!resp_vld) begin
            failures++;
            $display("FAIL ack_timeout got=%0b exp=1", resp_vld);
        end
        r = resp;
        @(negedge clk);
        resp_rdy = 1'b0;
    endtask

    task automatic send_data(logic [DPKT_W-1:0] p);
        int n = 0;
        data_vld = 1'b1;
        data = p;
        #1;
        while (!data_rdy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!data_rdy) begin
            failures++;
            $display("FAIL data_timeout got=%0b exp=1", data_rdy);
        end
        @(negedge clk);
        data_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++; if (evict_rdy !== 1'b1) begin failures++; $display("FAIL rst_evict_rdy got=%0b exp=1", evict_rdy); end
        checks++; if (resp_vld !== 1'b0) begin failures++; $display("FAIL rst_resp_vld got=%0b exp=0", resp_vld); end
        checks++; if (data_rdy !== 1'b1) begin failures++; $display("FAIL rst_data_rdy got=%0b exp=1", data_rdy); end
        checks++; if (mem_vld !== 1'b0) begin failures++; $display("FAIL rst_mem_vld got=%0b exp=0", mem_vld); end
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL rst_hit got=%0b exp=0", lk_hit); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
        do_reset();
    endtask

    task automatic test_evict();
        do_reset();
        lk_addr = 56'h1000;
        do_req(RT_EVICT, 56'h1000, 2'd1, 2'd0, 4'd5);
        #1;
        checks++; if (resp_vld !== 1'b1) begin failures++; $display("FAIL ev_resp_vld got=%0b exp=1", resp_vld); end
        checks++; if (resp !== mk_resp(2'd1, 2'd0, 4'd5, 2'd0)) begin failures++; $display("FAIL ev_resp got=%0h exp=%0h", resp, mk_resp(2'd1, 2'd0, 4'd5, 2'd0)); end
        checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL ev_hit got=%0b exp=1", lk_hit); end
        resp_rdy = 1'b1;
        @(negedge clk);
        resp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (resp_vld !== 1'b0) begin failures++; $display("FAIL ev_resp_after got=%0b exp=0", resp_vld); end
            checks++; if (mem_vld !== 1'b0) begin failures++; $display("FAIL ev_no_mem got=%0b exp=0", mem_vld); end
            checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL ev_free got=%0b exp=0", lk_hit); end
            @(negedge clk);
        end
    endtask

    task automatic test_full_wb();
        logic [RESP_W-1:0] r;
        logic [LINE_W-1:0] line;
        line = {16{8'hA5}};
        do_reset();
        lk_addr = 56'h2000;
        do_req(RT_WBF, 56'h2000, 2'd2, 2'd1, 4'd3);
        get_ack(r);
        checks++; if (r !== mk_resp(2'd2, 2'd1, 4'd3, 2'd0)) begin failures++; $display("FAIL wbf_ack got=%0h exp=%0h", r, mk_resp(2'd2, 2'd1, 4'd3, 2'd0)); end
        #1;
        checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL wbf_hit_data got=%0b exp=1", lk_hit); end
        send_data(mk_data(RT_WBFD, 2'd0, line, 2'b00));
        #1;
        checks++; if (mem_vld !== 1'b1) begin failures++; $display("FAIL wbf_mem_vld got=%0b exp=1", mem_vld); end
        checks++; if (mem_addr !== 56'h2000) begin failures++; $display("FAIL wbf_addr got=%0h exp=2000", mem_addr); end
        checks++; if (mem_data !== line) begin failures++; $display("FAIL wbf_data got=%0h exp=%0h", mem_data, line); end
        checks++; if (mem_strb !== 2'b11) begin failures++; $display("FAIL wbf_strb got=%0b exp=11", mem_strb); end
        checks++; if (data_rdy !== 1'b0) begin failures++; $display("FAIL wbf_data_rdy got=%0b exp=0", data_rdy); end
        mem_rdy = 1'b1;
        #1;
        checks++; if (lk_hit !== 1'b1) begin failures++; $display("FAIL wbf_hit_mem got=%0b exp=1", lk_hit); end
        @(negedge clk);
        mem_rdy = 1'b0;
        #1;
        checks++; if (mem_vld !== 1'b0) begin failures++; $display("FAIL wbf_mem_done got=%0b exp=0", mem_vld); end
        checks++; if (lk_hit !== 1'b0) begin failures++; $display("FAIL wbf_hit_done got=%0b exp=0", lk_hit); end
        checks++; if (data_rdy !== 1'b1) begin failures++; $display("FAIL wbf_rdy_back got=%0b exp=1", data_rdy); end
    endtask

    task automatic test_partial();
        logic [RESP_W-1:0] r;
        logic [LINE_W-1:0] line;
        line = {64'h2222_3333_4444_5555, 64'h1111_2222_3333_4444};
        do_reset();
        do_req(RT_WBP, 56'h3000, 2'd0, 2'd2, 4'd7);
        get_ack(r);
        checks++; if (r !== mk_resp(2'd0, 2'd2, 4'd7, 2'd0)) begin failures++; $display("FAIL wbp_ack got=%0h exp=%0h", r, mk_resp(2'd0, 2'd2, 4'd7, 2'd0)); end
        send_data(mk_data(RT_WBPD, 2'd0, line, 2'b01));
        #1;
        checks++; if (mem_vld !== 1'b1) begin failures++; $display("FAIL wbp_mem_vld got=%0b exp=1", mem_vld); end
        checks++; if (mem_strb !== 2'b01) begin failures++; $display("FAIL wbp_strb got=%0b exp=01", mem_strb); end
        checks++; if (mem_addr !== 56'h3000) begin failures++; $display("FAIL wbp_addr got=%0h exp=3000", mem_addr); end
        checks++; if (mem_data !== line) begin failures++; $display("FAIL wbp_data got=%0h exp=%0h", mem_data, line); end
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
    endtask

    task automatic test_fill();
        logic [RESP_W-1:0] r;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_req(RT_WBF, ADDR_W'(32'h100 + i), 2'd1, 2'd1, 4'(i));
        end
        #1;
        checks++; if (evict_rdy !== 1'b0) begin failures++; $display("FAIL fill_rdy_full got=%0b exp=0", evict_rdy); end
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (resp_vld !== 1'b1 || resp[5:4] !== 2'(i)) begin failures++; $display("FAIL fill_ack_order got=%0b/%0d exp=1/%0d", resp_vld, resp[5:4], i); end
            @(negedge clk);
        end
        resp_rdy = 1'b0;
        #1;
        checks++; if (evict_rdy !== 1'b0) begin failures++; $display("FAIL fill_rdy_data got=%0b exp=0", evict_rdy); end
        send_data(mk_data(RT_WBFD, 2'd2, {16{8'h3C}}, 2'b00));
        #1;
        checks++; if (mem_addr !== 56'h102) begin failures++; $display("FAIL fill_addr got=%0h exp=102", mem_addr); end
        mem_rdy = 1'b1;
        #1;
        checks++; if (evict_rdy !== 1'b0) begin failures++; $display("FAIL fill_no_realloc got=%0b exp=0", evict_rdy); end
        @(negedge clk);
        mem_rdy = 1'b0;
        #1;
        checks++; if (evict_rdy !== 1'b1) begin failures++; $display("FAIL fill_rdy_rise got=%0b exp=1", evict_rdy); end
        do_req(RT_EVICT, 56'h200, 2'd0, 2'd0, 4'd0);
        get_ack(r);
        checks++; if (r[5:4] !== 2'd2) begin failures++; $display("FAIL fill_reuse_tid got=%0d exp=2", r[5:4]); end
    endtask

    task automatic test_back_to_back();
        logic [RESP_W-1:0] r;
        logic [LINE_W-1:0] l0, l1;
        l0 = {2{64'h0123_4567_89AB_CDEF}};
        l1 = {2{64'hFEDC_BA98_7654_3210}};
        do_reset();
        do_req(RT_WBF, 56'h500, 2'd0, 2'd0, 4'd1);
        do_req(RT_WBF, 56'h501, 2'd0, 2'd0, 4'd2);
        get_ack(r);
        get_ack(r);
        checks++; if (r[5:4] !== 2'd1) begin failures++; $display("FAIL b2b_second_tid got=%0d exp=1", r[5:4]); end
        send_data(mk_data(RT_WBFD, 2'd0, l0, 2'b00));
        data_vld = 1'b1;
        data = mk_data(RT_WBFD, 2'd1, l1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (data_rdy !== 1'b0) begin failures++; $display("FAIL b2b_rdy_hold got=%0b exp=0", data_rdy); end
            checks++; if (mem_vld !== 1'b1 || mem_addr !== 56'h500 || mem_data !== l0) begin failures++; $display("FAIL b2b_stable got=%0b/%0h exp=1/500", mem_vld, mem_addr); end
            @(negedge clk);
        end
        mem_rdy = 1'b1;
        #1;
        checks++; if (data_rdy !== 1'b0) begin failures++; $display("FAIL b2b_no_bypass got=%0b exp=0", data_rdy); end
        @(negedge clk);
        mem_rdy = 1'b0;
        #1;
        checks++; if (data_rdy !== 1'b1 || mem_vld !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b/%0b exp=1/0", data_rdy, mem_vld); end
        @(negedge clk);
        data_vld = 1'b0;
        #1;
        checks++; if (mem_vld !== 1'b1 || mem_addr !== 56'h501 || mem_data !== l1) begin failures++; $display("FAIL b2b_second got=%0b/%0h exp=1/501", mem_vld, mem_addr); end
        mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
    endtask

    task automatic test_errors();
        logic [RESP_W-1:0] r;
        do_reset();
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_init got=%0b exp=0", err); end
        send_data(mk_data(RT_WBFD, 2'd3, {16{8'h77}}, 2'b00));
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_stray got=%0b exp=1", err); end
        checks++; if (mem_vld !== 1'b0 || data_rdy !== 1'b1) begin failures++; $display("FAIL err_dropped got=%0b/%0b exp=0/1", mem_vld, data_rdy); end
        lk_addr = 56'h700;
        do_req(4'hF, 56'h700, 2'd1, 2'd1, 4'd1);
        #1;
        checks++; if (resp_vld !== 1'b0 || lk_hit !== 1'b0) begin failures++; $display("FAIL err_bad_rtype got=%0b/%0b exp=0/0", resp_vld, lk_hit); end
        do_req(RT_EVICT, 56'h710, 2'd3, 2'd3, 4'd9);
        get_ack(r);
        checks++; if (r !== mk_resp(2'd3, 2'd3, 4'd9, 2'd0)) begin failures++; $display("FAIL err_after_ack got=%0h exp=%0h", r, mk_resp(2'd3, 2'd3, 4'd9, 2'd0)); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
    endtask

    task automatic test_reset_mid();
        logic [RESP_W-1:0] r;
        do_reset();
        lk_addr = 56'h800;
        do_req(RT_WBF, 56'h800, 2'd1, 2'd1, 4'd1);
        get_ack(r);
        send_data(mk_data(RT_WBFD, 2'd0, {16{8'h5A}}, 2'b00));
        #1;
        checks++; if (mem_vld !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0b exp=1", mem_vld); end
        rst = 1'b0;
        #1;
        checks++; if (mem_vld !== 1'b0) begin failures++; $display("FAIL rmid_mem got=%0b exp=0", mem_vld); end
        checks++; if (evict_rdy !== 1'b1 || data_rdy !== 1'b1) begin failures++; $display("FAIL rmid_rdy got=%0b/%0b exp=1/1", evict_rdy, data_rdy); end
        checks++; if (lk_hit !== 1'b0 || resp_vld !== 1'b0) begin failures++; $display("FAIL rmid_entries got=%0b/%0b exp=0/0", lk_hit, resp_vld); end
        @(negedge clk);
        rst = 1'b1;
        mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (mem_vld !== 1'b0) begin failures++; $display("FAIL rmid_no_write got=%0b exp=0", mem_vld); end
            @(negedge clk);
        end
        mem_rdy = 1'b0;
        do_req(RT_EVICT, 56'h900, 2'd2, 2'd2, 4'd2);
        get_ack(r);
        checks++; if (r[5:4] !== 2'd0) begin failures++; $display("FAIL rmid_realloc got=%0d exp=0", r[5:4]); end
    endtask

    initial begin
        test_reset();
        test_evict();
        test_full_wb();
        test_partial();
        test_fill();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
